// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state type, byte-lane constants and the alignment check helper.
package lsu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    // Byte-lane helper constants (little-endian lanes inside a 32-bit word)
    localparam int          LANE_BITS      = 8;
    localparam int          LANE_COUNT     = 4;
    localparam logic [31:0] LANE_BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] LANE_HALF_MASK = 32'h0000_FFFF;
    localparam logic [31:0] LANE_WORD_MASK = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    // True when the byte offset is not naturally aligned for the size;
    // the reserved size is always reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = offset[0];
            SIZE_W:  mis = (offset != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle around the load/store unit: the core request/response channel
// and the word-wide data-memory port. The slave view is the unit itself;
// the master view is its environment (core plus memory).
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_error;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_write_data;
    logic [31:0]           mem_read_data;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_write_enable, mem_address, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_write_enable, mem_address, mem_write_data
    );
endinterface

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: extracts and sign/zero-extends sub-word loads
// and merges sub-word store data into the word read back from memory.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  shift_s;
    logic [31:0] lane_mask_s;
    logic [31:0] rd_shift_s;
    logic [31:0] wd_shift_s;

    // Bit shift and lane mask of the addressed byte/half/word
    always_comb begin
        shift_s     = 5'd0;
        lane_mask_s = 32'h0000_0000;
        case (size)
            SIZE_B: begin
                shift_s     = {offset, 3'b000};
                lane_mask_s = LANE_BYTE_MASK << {offset, 3'b000};
            end
            SIZE_H: begin
                shift_s     = {offset[1], 4'b0000};
                lane_mask_s = LANE_HALF_MASK << {offset[1], 4'b0000};
            end
            SIZE_W: begin
                shift_s     = 5'd0;
                lane_mask_s = LANE_WORD_MASK;
            end
            default: begin
                shift_s     = 5'd0;
                lane_mask_s = 32'h0000_0000;
            end
        endcase
    end

    assign rd_shift_s = rdata >> shift_s;
    assign wd_shift_s = wdata << shift_s;

    // Load extraction with sign or zero extension
    always_comb begin
        load_data = 32'h0000_0000;
        case (size)
            SIZE_B: begin
                if (is_unsigned) begin
                    load_data = {24'h00_0000, rd_shift_s[7:0]};
                end else begin
                    load_data = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
                end
            end
            SIZE_H: begin
                if (is_unsigned) begin
                    load_data = {16'h0000, rd_shift_s[15:0]};
                end else begin
                    load_data = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
                end
            end
            SIZE_W:  load_data = rdata;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store merge: new lanes from wdata, untouched lanes from memory
    always_comb begin
        merge_data = (rdata & ~lane_mask_s) | (wd_shift_s & lane_mask_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, drives a word-wide data memory
// with async read / sync write. Sub-word stores use read-modify-write.
// Every output is a flop so the memory and core see glitch-free signals.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);

    lsu_state_e state_r;
    lsu_state_e state_nxt_s;

    logic [1:0]            size_r;
    logic                  unsigned_r;
    logic [1:0]            offset_r;
    logic [31:0]           wdata_r;

    logic                  accept_s;
    logic                  req_err_s;
    logic [ADDR_WIDTH-1:0] addr_aligned_s;
    logic [31:0]           load_data_s;
    logic [31:0]           merge_data_s;

    logic                  req_ready_r;
    logic                  resp_valid_r;
    logic [31:0]           resp_rdata_r;
    logic                  resp_error_r;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_address_r;
    logic [31:0]           mem_wdata_r;

    assign accept_s = (state_r == ST_IDLE) && bus.req_valid;

    // Error decision and address alignment for an incoming request
    always_comb begin
        addr_aligned_s = bus.req_addr;
        if (ERR_ON_MISALIGN) begin
            req_err_s = is_misaligned(bus.req_size, bus.req_addr[1:0]);
        end else begin
            req_err_s = (bus.req_size == SIZE_RSV);
            if (bus.req_size == SIZE_H) begin
                addr_aligned_s[0] = 1'b0;
            end else if (bus.req_size == SIZE_W) begin
                addr_aligned_s[1:0] = 2'b00;
            end else begin
                addr_aligned_s = bus.req_addr;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!bus.req_valid) begin
                    state_nxt_s = ST_IDLE;
                end else if (req_err_s) begin
                    state_nxt_s = ST_RESP;
                end else if (!bus.req_write) begin
                    state_nxt_s = ST_LOAD;
                end else if (bus.req_size == SIZE_W) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_RMW_RD;
                end
            end
            ST_LOAD:   state_nxt_s = ST_RESP;
            ST_RMW_RD: state_nxt_s = ST_WRITE;
            ST_WRITE:  state_nxt_s = ST_RESP;
            ST_RESP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    lsu_lane_unit u_lane (
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .offset      (offset_r),
        .rdata       (bus.mem_read_data),
        .wdata       (wdata_r),
        .load_data   (load_data_s),
        .merge_data  (merge_data_s)
    );

    // Request latch, registered outputs and memory-port flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_r        <= 2'b00;
            unsigned_r    <= 1'b0;
            offset_r      <= 2'b00;
            wdata_r       <= 32'h0000_0000;
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= 32'h0000_0000;
            resp_error_r  <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_address_r <= '0;
            mem_wdata_r   <= 32'h0000_0000;
        end else begin
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
            mem_we_r     <= (state_nxt_s == ST_WRITE);
            resp_error_r <= accept_s && req_err_s;
            if (state_r == ST_LOAD) begin
                resp_rdata_r <= load_data_s;
            end else begin
                resp_rdata_r <= 32'h0000_0000;
            end
            if (accept_s) begin
                size_r        <= bus.req_size;
                unsigned_r    <= bus.req_unsigned;
                offset_r      <= addr_aligned_s[1:0];
                wdata_r       <= bus.req_wdata;
                mem_address_r <= {2'b00, addr_aligned_s[ADDR_WIDTH-1:2]};
                if (bus.req_write && (bus.req_size == SIZE_W) && !req_err_s) begin
                    mem_wdata_r <= bus.req_wdata;
                end else begin
                    mem_wdata_r <= mem_wdata_r;
                end
            end else if (state_r == ST_RMW_RD) begin
                mem_wdata_r <= merge_data_s;
            end else begin
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    assign bus.req_ready        = req_ready_r;
    assign bus.resp_valid       = resp_valid_r;
    assign bus.resp_rdata       = resp_rdata_r;
    assign bus.resp_error       = resp_error_r;
    assign bus.mem_write_enable = mem_we_r;
    assign bus.mem_address      = mem_address_r;
    assign bus.mem_write_data   = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses (data, error, response cycle); a monitor pops and compares.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   wcount;
    exp_t exp_q[$];
    logic [31:0] mem [0:63];

    load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32), .ERR_ON_MISALIGN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model: async read, write at the rising edge
    assign bus.mem_read_data = mem[bus.mem_address[5:0]];
    initial wcount = 0;
    always @(posedge clk) begin
        if (rst_n && bus.mem_write_enable) begin
            mem[bus.mem_address[5:0]] <= bus.mem_write_data;
            wcount <= wcount + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every response against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got resp_valid 1 expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_error", {31'd0, bus.resp_error}, {31'd0, e.err});
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got req_ready 0 expected 1");
        end else begin
            bus.req_valid    = 1'b1;
            bus.req_write    = wr;
            bus.req_size     = sz;
            bus.req_unsigned = uns;
            bus.req_addr     = addr;
            bus.req_wdata    = wd;
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.cyc   = cyc + lat;
            exp_q.push_back(e);
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        mem[3] = 32'h8899_AABB;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_we", {31'd0, bus.mem_write_enable}, 32'd0);
        check("rst_mem_address", bus.mem_address, 32'h0);
        check("rst_mem_wdata", bus.mem_write_data, 32'h0);

        // Sub-word loads
        issue(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 32'hFFFF_FFAA, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 32'h0000_0099, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, 32'hFFFF_FFBB, 1'b0, 2);
        issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h8899_AABB, 1'b0, 2);
        wait_idle();

        // Byte store: read-modify-write, one write
        w0 = wcount;
        issue(1'b1, 2'b00, 1'b0, 32'h0F, 32'h11, 32'h0, 1'b0, 3);
        wait_idle();
        check("sb_mem3", mem[3], 32'h1199_AABB);
        check("sb_writes", wcount - w0, 32'd1);

        // Half store then half loads
        issue(1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234, 32'h0, 1'b0, 3);
        wait_idle();
        check("sh_mem3", mem[3], 32'h1234_AABB);
        issue(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, 32'h0000_AABB, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, 32'hFFFF_AABB, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'h0000_1234, 1'b0, 2);
        wait_idle();

        // Errors: misaligned word, misaligned half, reserved size store
        w0 = wcount;
        issue(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b0, 2'b01, 1'b0, 32'h0D, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 2'b11, 1'b0, 32'h0C, 32'h77, 32'h0, 1'b1, 1);
        wait_idle();
        check("err_writes", wcount - w0, 32'd0);
        check("err_mem3", mem[3], 32'h1234_AABB);

        // Reset during RMW_RD of sb 0x0C
        w0 = wcount;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h0C;
        bus.req_wdata = 32'h55;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        check("abort_mem_we", {31'd0, bus.mem_write_enable}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort_mem3", mem[3], 32'h1234_AABB);
        check("abort_writes", wcount - w0, 32'd0);

        // Back-to-back word store then load
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        wait_idle();
        check("sw_mem4", mem[4], 32'hDEAD_BEEF);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
